// File: rtl/mod_counter_bank_if.sv
// Control and status bundle for mod_counter_bank: per-channel controls in, counts and tc out.
interface mod_counter_bank_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       up;
    logic [CHANNELS-1:0]       cascade;
    logic [CHANNELS*WIDTH-1:0] mod_val;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       tc;

    modport master (
        output en, up, cascade, mod_val, load, load_val,
        input  count, tc
    );

    modport slave (
        input  en, up, cascade, mod_val, load, load_val,
        output count, tc
    );
endinterface

// File: rtl/mod_counter_bank.sv
// Bank of independent run-time programmable modulo counters with optional
// single-cycle ripple cascading onto the wrap of the channel below.
module mod_counter_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mod_counter_bank_if.slave bus
);

    logic [CHANNELS*WIDTH-1:0] count_q;
    logic [CHANNELS*WIDTH-1:0] count_d;
    logic [CHANNELS-1:0]       tc_q;
    logic [CHANNELS-1:0]       wrap;

    always_comb begin : next_count
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] ld;
        logic [WIDTH-1:0] nxt;
        logic             over;
        logic             step;
        logic             w;
        logic             carry;

        count_d = count_q;
        wrap    = '0;
        carry   = 1'b0;
        cur     = '0;
        m       = '0;
        top     = '0;
        ld      = '0;
        nxt     = '0;
        over    = 1'b0;
        step    = 1'b0;
        w       = 1'b0;

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cur = count_q[i*WIDTH +: WIDTH];
            m   = bus.mod_val[i*WIDTH +: WIDTH];
            ld  = bus.load_val[i*WIDTH +: WIDTH];
            // mod_val of zero means 2^WIDTH, so top wraps to all-ones and nothing is out of range
            top  = m - WIDTH'(1);
            over = (m != '0) && (cur >= m);
            step = bus.en[i] && ((i == 0) || !bus.cascade[i] || carry);
            nxt  = cur;
            w    = 1'b0;

            if (bus.load[i]) begin
                nxt = ((m == '0) || (ld < m)) ? ld : top;
            end else if (step) begin
                if (bus.up[i]) begin
                    if ((cur == top) || over) begin
                        nxt = '0;
                        w   = 1'b1;
                    end else begin
                        nxt = cur + WIDTH'(1);
                    end
                end else begin
                    if (cur == '0) begin
                        nxt = top;
                        w   = 1'b1;
                    end else if (over) begin
                        nxt = top;
                    end else begin
                        nxt = cur - WIDTH'(1);
                    end
                end
            end

            count_d[i*WIDTH +: WIDTH] = nxt;
            wrap[i] = w;
            carry   = w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= wrap;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_mod_counter_bank.sv
// Directed scoreboard bench for mod_counter_bank (WIDTH=8, CHANNELS=4).
module tb_mod_counter_bank;
    localparam int W  = 8;
    localparam int CH = 4;

    typedef struct packed {
        logic [CH*W-1:0] cnt;
        logic [CH-1:0]   tc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    int   m_cnt[CH];

    mod_counter_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    mod_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent model of one clock edge from the currently driven inputs.
    function automatic exp_t model_next();
        exp_t e;
        bit   carry;
        carry = 1'b0;
        e     = '0;
        for (int i = 0; i < CH; i++) begin
            int  mv, meff, ld, cur, nxt;
            bit  stp, w;
            mv   = int'(bus.mod_val[i*W +: W]);
            ld   = int'(bus.load_val[i*W +: W]);
            meff = (mv == 0) ? 256 : mv;
            cur  = m_cnt[i];
            nxt  = cur;
            w    = 1'b0;
            stp  = bus.en[i] && (i == 0 || !bus.cascade[i] || carry);
            if (bus.load[i]) begin
                nxt = (ld < meff) ? ld : meff - 1;
            end else if (stp) begin
                if (bus.up[i]) begin
                    if (cur >= meff - 1) begin nxt = 0; w = 1'b1; end
                    else nxt = cur + 1;
                end else begin
                    if (cur == 0) begin nxt = meff - 1; w = 1'b1; end
                    else if (cur >= meff) nxt = meff - 1;
                    else nxt = cur - 1;
                end
            end
            m_cnt[i]         = nxt;
            e.cnt[i*W +: W]  = W'(nxt);
            e.tc[i]          = w;
            carry            = w;
        end
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        sb.push_back(model_next());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_count", bus.count, e.cnt);
        chk("sb_tc", 32'(bus.tc), 32'(e.tc));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        chk("rst_count", bus.count, 32'd0);
        chk("rst_tc", 32'(bus.tc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        bus.en       = '0;
        bus.up       = '1;
        bus.cascade  = '0;
        bus.load     = '0;
        bus.load_val = '0;
        bus.mod_val  = {8'd16, 8'd7, 8'd5, 8'd3};

        // Reset state and free run
        #12;
        chk("reset_count", bus.count, 32'd0);
        chk("reset_tc", 32'(bus.tc), 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        bus.en = '1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k % 3 == 0) chk("free_tc0", 32'(bus.tc[0]), 32'd1);
            if (k == 15) chk("free_ch3_15", 32'(bus.count[31:24]), 32'd15);
            if (k == 16) begin
                chk("free_ch3_wrap", 32'(bus.count[31:24]), 32'd0);
                chk("free_tc3", 32'(bus.tc[3]), 32'd1);
            end
        end

        // Asynchronous reset between edges
        #1;
        rst = 1'b0;
        #1;
        chk("async_count", bus.count, 32'd0);
        chk("async_tc", 32'(bus.tc), 32'd0);
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        bus.en      = 4'b0001;
        bus.up      = 4'b1110;
        bus.mod_val = {8'd16, 8'd7, 8'd5, 8'd10};
        @(negedge clk);
        rst = 1'b1;

        // Down count
        cycle();
        chk("down_first", 32'(bus.count[7:0]), 32'd9);
        chk("down_tc", 32'(bus.tc[0]), 32'd1);
        cycle();
        chk("down_8", 32'(bus.count[7:0]), 32'd8);
        cycle();
        chk("down_7", 32'(bus.count[7:0]), 32'd7);

        // Down with M=0
        bus.mod_val  = {8'd16, 8'd7, 8'd5, 8'd0};
        bus.load     = 4'b0001;
        bus.load_val = '0;
        cycle();
        bus.load = '0;
        cycle();
        chk("m0_255", 32'(bus.count[7:0]), 32'd255);
        chk("m0_tc", 32'(bus.tc[0]), 32'd1);
        cycle();
        chk("m0_254", 32'(bus.count[7:0]), 32'd254);
        chk("m0_tc_low", 32'(bus.tc[0]), 32'd0);

        // Cascade chain
        do_reset();
        bus.mod_val = {8'd0, 8'd0, 8'd6, 8'd10};
        bus.cascade = 4'b0110;
        bus.en      = '1;
        bus.up      = '1;
        for (int k = 1; k <= 60; k++) cycle();
        chk("casc_ch1", 32'(bus.count[15:8]), 32'd0);
        chk("casc_tc1", 32'(bus.tc[1]), 32'd1);
        chk("casc_ch2", 32'(bus.count[23:16]), 32'd1);

        // Load beats cascade carry
        do_reset();
        bus.en       = '0;
        bus.load     = 4'b0001;
        bus.load_val = {8'd0, 8'd0, 8'd0, 8'd9};
        cycle();
        bus.en       = 4'b0011;
        bus.load     = 4'b0010;
        bus.load_val = {8'd0, 8'd0, 8'd4, 8'd0};
        cycle();
        chk("ldpri_ch1", 32'(bus.count[15:8]), 32'd4);
        chk("ldpri_tc1", 32'(bus.tc[1]), 32'd0);
        chk("ldpri_tc0", 32'(bus.tc[0]), 32'd1);
        bus.en       = '0;
        bus.load     = 4'b0001;
        bus.load_val = {8'd0, 8'd0, 8'd0, 8'd9};
        cycle();
        bus.en       = 4'b0011;
        bus.load     = 4'b0010;
        bus.load_val = {8'd0, 8'd0, 8'd20, 8'd0};
        cycle();
        chk("ldclamp_ch1", 32'(bus.count[15:8]), 32'd5);

        // Runtime modulus shrink, up then down
        bus.en       = '0;
        bus.mod_val  = {8'd0, 8'd0, 8'd6, 8'd16};
        bus.load     = 4'b0001;
        bus.load_val = {8'd0, 8'd0, 8'd0, 8'd12};
        cycle();
        bus.load    = '0;
        bus.mod_val = {8'd0, 8'd0, 8'd6, 8'd8};
        bus.en      = 4'b0001;
        cycle();
        chk("shrink_up", 32'(bus.count[7:0]), 32'd0);
        chk("shrink_up_tc", 32'(bus.tc[0]), 32'd1);
        bus.en      = '0;
        bus.mod_val = {8'd0, 8'd0, 8'd6, 8'd16};
        bus.load    = 4'b0001;
        cycle();
        bus.load    = '0;
        bus.mod_val = {8'd0, 8'd0, 8'd6, 8'd8};
        bus.up      = 4'b1110;
        bus.en      = 4'b0001;
        cycle();
        chk("shrink_dn", 32'(bus.count[7:0]), 32'd7);
        chk("shrink_dn_tc", 32'(bus.tc[0]), 32'd0);

        // M=1 with enable gating
        bus.mod_val = {8'd0, 8'd0, 8'd6, 8'd1};
        bus.up      = '1;
        for (int j = 0; j < 4; j++) begin
            bus.en = {3'b000, pat[j]};
            cycle();
            chk("m1_count", 32'(bus.count[7:0]), 32'd0);
            chk("m1_tc", 32'(bus.tc[0]), 32'(pat[j]));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mod_counter_bank.md
# mod_counter_bank

Parametrised bank of independent modulo counters. Each channel has a run-time programmable modulus, count direction, enable, synchronous load and a registered terminal-count pulse. Any channel above channel 0 can be cascaded onto the wrap of the channel below it, forming multi-digit mixed-radix counters. It is the general-purpose successor to the team's fixed mod-3/5/7/8/16 counters and is used wherever the design needs divide-by-N ticks or timebase chains.

## Interface
- WIDTH, 8, bit width of each channel's count, modulus and load value
- CHANNELS, 4, number of counter channels (≥1)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  CHANNELS  per-channel count enable
- up  in  CHANNELS  per-channel direction: 1 = count up, 0 = count down
- cascade  in  CHANNELS  bit i=1 makes channel i advance only on channel i-1 wrap; bit 0 ignored
- mod_val  in  CHANNELS*WIDTH  modulus M per channel, channel i at [i*WIDTH +: WIDTH]; 0 means 2^WIDTH
- load  in  CHANNELS  per-channel synchronous load strobe
- load_val  in  CHANNELS*WIDTH  per-channel load value, same packing as mod_val
- count  out  CHANNELS*WIDTH  registered count per channel, same packing
- tc  out  CHANNELS  registered terminal-count pulse, one cycle per wrap

## Operation
- Each channel's legal range is 0..M-1. Effective modulus Meff = 2^WIDTH when mod_val = 0, otherwise mod_val.
- Step condition: step[i] = en[i] & (i==0 | ~cascade[i] | wrap[i-1]). wrap[i-1] is the combinational same-cycle wrap of the lower channel, so a whole chain ripples in one cycle.
- Up step:
  - count == Meff-1 → 0, wrap = 1.
  - count ≥ Meff (modulus lowered at run time) → 0, wrap = 1.
  - Otherwise → count+1, wrap = 0.
- Down step:
  - count == 0 → Meff-1, wrap = 1.
  - count ≥ Meff → Meff-1, wrap = 0.
  - Otherwise → count-1, wrap = 0.
- Meff = 1: count stays 0 and every step is a wrap. A single channel with M=1 divides its enable rate by 1.
- Load has priority over step:
  - load[i]=1 → count ← load_val if load_val < Meff, else Meff-1.
  - A load never produces a wrap. It therefore breaks the cascade carry to channel i+1 for that cycle, even if en and the roll-over condition hold.
- wrap[i] is only asserted when step[i] is true and load[i] is false.
- tc[i] ← wrap[i] registered. It is asserted in the cycle in which count shows the wrapped value: 0 for up, Meff-1 for down.
- Changing up, mod_val or cascade takes effect on the next edge. No state other than count and tc exists.
- Arithmetic is modulo 2^WIDTH internally. Meff-1 for mod_val=0 is all-ones. No carry beyond WIDTH bits is kept.

## Timing
- Reset (rst=0, asynchronous): all count = 0, all tc = 0, held while rst low. Release is synchronous to clk; the first step can occur on the first rising edge with rst=1.
- Reset asserted mid-count clears count and tc immediately, with no wait for a clock edge.
- Latency:
  - en → count change: 1 cycle.
  - load → count = load value: 1 cycle.
  - Wrap → tc high: same edge as the count wrap. tc lasts exactly 1 cycle unless the next step also wraps (for example M=1), in which case tc stays high.
- Cascade chain: channel k's wrap depends combinationally on channels 0..k-1. The critical path grows with CHANNELS; it is acceptable up to CHANNELS=8 at WIDTH=8.
- Simultaneous load[i] and wrap[i-1] with cascade[i]=1: the load wins, channel i takes load_val, and there is no wrap.

## Test plan
- Reset and free-run: WIDTH=8, CHANNELS=4, M={3,5,7,16}, all up, en=1, cascade=0; run 20 cycles after reset release.
  - Required: channel 0 sequence 0,1,2,0,…
  - Required: tc[0] high in cycles 3, 6, 9, …
  - Required: channel 3 reaches 15, then 0 with tc[3] in cycle 16.
  - Mid-run rst=0: all count=0 and tc=0 without a clock edge.
- Down count and M=0: channel 0 up=0, M=10, reset value 0.
  - Required: the first step gives 9 with tc[0]=1, followed by 8, 7, …
  - With M=0: 0→255 with tc, then 254.
- Cascade: M={10,6,0,0}, cascade={0,1,1,0}, en all 1; run 60 cycles.
  - Required: channel 1 increments once per channel-0 wrap.
  - Required: after 60 cycles channel 1 = 0 with tc[1]=1, and channel 2 = 1.
- Load priority: channel 0 at 9 (M=10), load[1]=1, load_val=4, cascade[1]=1 in the wrap cycle.
  - Required: channel 1 = 4, tc[1]=0.
  - With load_val=20, M=6: channel 1 = 5.
- Runtime modulus shrink: channel 0 at 12, change M from 16 to 8.
  - Up: the next step gives 0 with tc=1.
  - Down (repeat from 12): the next step gives 7 with tc=0.
- Degenerate M=1 and enable gating: en toggled 1,0,1,1.
  - Required: count stays 0.
  - Required: tc pattern 1,0,1,1, delayed one cycle.
